// File: rtl/bus_arb_pkg.sv
// Shared types and sel encodings for the split-capable serial bus arbiter.
package bus_arb_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    GNT_I1    = 3'd1,
    GNT_I2    = 3'd2,
    GNT_SPLIT = 3'd3,
    HANDOVER  = 3'd4
  } arb_state_t;

  localparam logic [1:0] SEL_IDLE  = 2'b00;
  localparam logic [1:0] SEL_I1    = 2'b01;
  localparam logic [1:0] SEL_I2    = 2'b10;
  localparam logic [1:0] SEL_SPLIT = 2'b11;

  // Forward-mux steering code for a given arbiter state.
  function automatic logic [1:0] state_to_sel(input arb_state_t st);
    logic [1:0] code;
    case (st)
      GNT_I1:    code = SEL_I1;
      GNT_I2:    code = SEL_I2;
      GNT_SPLIT: code = SEL_SPLIT;
      default:   code = SEL_IDLE;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/grant_timer.sv
// Grant-hold watchdog: counts granted cycles, saturating, and flags the last
// permitted cycle of a grant.
module grant_timer
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_r;

  // Hold-time counter; saturates at the last permitted cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LAST_COUNT)) begin
      count_r <= count_r + CW'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == LAST_COUNT);

endmodule

// File: rtl/split_rr_arbiter.sv
// Registered round-robin bus arbiter for two initiators plus a split target
// return path, with outstanding-split tracking and a grant-hold watchdog.
module split_rr_arbiter
  import bus_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter bit TIMEOUT_EN     = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_i_1,
  input  logic       req_i_2,
  input  logic       req_split,
  input  logic       split_issued,
  input  logic       split_done,
  output logic       grant_i_1,
  output logic       grant_i_2,
  output logic       grant_split,
  output logic [1:0] sel,
  output logic       split_pending,
  output logic       split_owner,
  output logic       timeout_err,
  output logic       split_overflow
);

  arb_state_t state_r, state_nxt_s;
  logic       rr_ptr_r, rr_ptr_nxt_s;          // 0 prefers initiator 0 on a tie
  logic       pending_r, pending_nxt_s;
  logic       owner_r, owner_nxt_s;
  logic       overflow_r, overflow_nxt_s;
  logic       timeout_s, timeout_err_r;
  logic       grant_i_1_r, grant_i_2_r, grant_split_r;
  logic [1:0] sel_r;

  logic       elig_i1_s, elig_i2_s, elig_split_s;
  logic       granted_s, timer_expired_s, wd_expired_s;

  // Arbitration decision from eligible requests: split first, then round-robin.
  function automatic arb_state_t pick_grant(input logic e_split, input logic e_i1,
                                            input logic e_i2, input logic ptr);
    arb_state_t st;
    if (e_split) begin
      st = GNT_SPLIT;
    end else if (e_i1 && e_i2) begin
      st = ptr ? GNT_I2 : GNT_I1;
    end else if (e_i1) begin
      st = GNT_I1;
    end else if (e_i2) begin
      st = GNT_I2;
    end else begin
      st = IDLE;
    end
    return st;
  endfunction

  // The split owner stays off the bus until the target returns its data.
  assign elig_split_s = req_split & pending_r;
  assign elig_i1_s    = req_i_1 & ~(pending_r & ~owner_r);
  assign elig_i2_s    = req_i_2 & ~(pending_r & owner_r);

  assign granted_s = (state_r == GNT_I1) || (state_r == GNT_I2) || (state_r == GNT_SPLIT);

  grant_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_grant_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (~granted_s),
    .enable (granted_s),
    .expired(timer_expired_s)
  );

  assign wd_expired_s = TIMEOUT_EN & timer_expired_s;

  // Next-state, RR pointer and split bookkeeping.
  always_comb begin
    state_nxt_s    = state_r;
    rr_ptr_nxt_s   = rr_ptr_r;
    pending_nxt_s  = pending_r;
    owner_nxt_s    = owner_r;
    overflow_nxt_s = overflow_r;
    timeout_s      = 1'b0;

    case (state_r)
      IDLE, HANDOVER: begin
        state_nxt_s = pick_grant(elig_split_s, elig_i1_s, elig_i2_s, rr_ptr_r);
      end
      GNT_I1: begin
        if (!req_i_1) begin
          state_nxt_s  = HANDOVER;
          rr_ptr_nxt_s = 1'b1;
        end else if (wd_expired_s) begin
          state_nxt_s  = HANDOVER;
          rr_ptr_nxt_s = 1'b1;
          timeout_s    = 1'b1;
        end else begin
          state_nxt_s = GNT_I1;
        end
      end
      GNT_I2: begin
        if (!req_i_2) begin
          state_nxt_s  = HANDOVER;
          rr_ptr_nxt_s = 1'b0;
        end else if (wd_expired_s) begin
          state_nxt_s  = HANDOVER;
          rr_ptr_nxt_s = 1'b0;
          timeout_s    = 1'b1;
        end else begin
          state_nxt_s = GNT_I2;
        end
      end
      GNT_SPLIT: begin
        if (split_done || !req_split) begin
          state_nxt_s   = HANDOVER;
          pending_nxt_s = 1'b0;
        end else if (wd_expired_s) begin
          // Forced release keeps the split outstanding so the target can retry.
          state_nxt_s  = HANDOVER;
          rr_ptr_nxt_s = ~rr_ptr_r;
          timeout_s    = 1'b1;
        end else begin
          state_nxt_s = GNT_SPLIT;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    if (split_issued && ((state_r == GNT_I1) || (state_r == GNT_I2))) begin
      if (!pending_r) begin
        pending_nxt_s = 1'b1;
        owner_nxt_s   = (state_r == GNT_I2);
      end else begin
        overflow_nxt_s = 1'b1;
      end
    end else begin
      overflow_nxt_s = overflow_r;
    end
  end

  // State, bookkeeping and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      rr_ptr_r      <= 1'b0;
      pending_r     <= 1'b0;
      owner_r       <= 1'b0;
      overflow_r    <= 1'b0;
      timeout_err_r <= 1'b0;
      grant_i_1_r   <= 1'b0;
      grant_i_2_r   <= 1'b0;
      grant_split_r <= 1'b0;
      sel_r         <= SEL_IDLE;
    end else begin
      state_r       <= state_nxt_s;
      rr_ptr_r      <= rr_ptr_nxt_s;
      pending_r     <= pending_nxt_s;
      owner_r       <= owner_nxt_s;
      overflow_r    <= overflow_nxt_s;
      timeout_err_r <= timeout_s;
      grant_i_1_r   <= (state_nxt_s == GNT_I1);
      grant_i_2_r   <= (state_nxt_s == GNT_I2);
      grant_split_r <= (state_nxt_s == GNT_SPLIT);
      sel_r         <= state_to_sel(state_nxt_s);
    end
  end

  assign grant_i_1      = grant_i_1_r;
  assign grant_i_2      = grant_i_2_r;
  assign grant_split    = grant_split_r;
  assign sel            = sel_r;
  assign split_pending  = pending_r;
  assign split_owner    = owner_r;
  assign timeout_err    = timeout_err_r;
  assign split_overflow = overflow_r;

endmodule

// File: tb/tb_split_rr_arbiter.sv
// Directed cycle-by-cycle vectors for split_rr_arbiter plus a watchdog sequence.
module tb_split_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst, req_i_1, req_i_2, req_split, split_issued, split_done;
  logic       grant_i_1, grant_i_2, grant_split, split_pending, split_owner;
  logic       timeout_err, split_overflow;
  logic [1:0] sel;

  int checks = 0;
  int errors = 0;

  // in : {rst, req_i_1, req_i_2, req_split, split_issued, split_done}
  // exp: {grant_i_1, grant_i_2, grant_split, sel[1:0], split_pending, split_owner, timeout_err, split_overflow}
  typedef struct packed {
    logic [5:0] in;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  split_rr_arbiter #(
    .TIMEOUT_CYCLES(8),
    .TIMEOUT_EN    (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_i_1       (req_i_1),
    .req_i_2       (req_i_2),
    .req_split     (req_split),
    .split_issued  (split_issued),
    .split_done    (split_done),
    .grant_i_1     (grant_i_1),
    .grant_i_2     (grant_i_2),
    .grant_split   (grant_split),
    .sel           (sel),
    .split_pending (split_pending),
    .split_owner   (split_owner),
    .timeout_err   (timeout_err),
    .split_overflow(split_overflow)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [5:0] in, input logic [8:0] exp);
    vec_t v;
    v.in  = in;
    v.exp = exp;
    return v;
  endfunction

  function automatic logic [8:0] outs();
    return {grant_i_1, grant_i_2, grant_split, sel, split_pending, split_owner,
            timeout_err, split_overflow};
  endfunction

  task automatic step_check(input logic [5:0] in, input logic [8:0] exp, input string name);
    {rst, req_i_1, req_i_2, req_split, split_issued, split_done} = in;
    @(posedge clk);
    #1;
    checks++;
    if (outs() !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, outs(), exp);
    end
  endtask

  initial begin
    {rst, req_i_1, req_i_2, req_split, split_issued, split_done} = 6'b100000;

    // reset
    vecs.push_back(mk(6'b100000, 9'b000000000));
    vecs.push_back(mk(6'b100000, 9'b000000000));
    // round-robin: initiator 0 five cycles, turnaround, initiator 1 five cycles
    vecs.push_back(mk(6'b011000, 9'b100010000));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(6'b011000, 9'b100010000));
    vecs.push_back(mk(6'b001000, 9'b000000000));
    vecs.push_back(mk(6'b011000, 9'b010100000));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(6'b011000, 9'b010100000));
    vecs.push_back(mk(6'b010000, 9'b000000000));
    vecs.push_back(mk(6'b000000, 9'b000000000));
    // spurious split return with nothing pending
    vecs.push_back(mk(6'b000100, 9'b000000000));
    vecs.push_back(mk(6'b000100, 9'b000000000));
    // split issued to initiator 0, owner masked, overflow on second issue
    vecs.push_back(mk(6'b010000, 9'b100010000));
    vecs.push_back(mk(6'b010010, 9'b100011000));
    vecs.push_back(mk(6'b000000, 9'b000001000));
    vecs.push_back(mk(6'b010000, 9'b000001000));
    vecs.push_back(mk(6'b011000, 9'b010101000));
    vecs.push_back(mk(6'b011010, 9'b010101001));
    vecs.push_back(mk(6'b010000, 9'b000001001));
    vecs.push_back(mk(6'b010000, 9'b000001001));
    // split return beats initiator 1, split_done releases
    vecs.push_back(mk(6'b001100, 9'b001111001));
    vecs.push_back(mk(6'b001100, 9'b001111001));
    vecs.push_back(mk(6'b001101, 9'b000000001));
    vecs.push_back(mk(6'b001000, 9'b010100001));
    vecs.push_back(mk(6'b000000, 9'b000000001));
    vecs.push_back(mk(6'b000000, 9'b000000001));
    // split owned by initiator 1, then reset during GNT_SPLIT
    vecs.push_back(mk(6'b001000, 9'b010100001));
    vecs.push_back(mk(6'b001010, 9'b010101101));
    vecs.push_back(mk(6'b000000, 9'b000001101));
    vecs.push_back(mk(6'b000100, 9'b001111101));
    vecs.push_back(mk(6'b100100, 9'b000000000));
    vecs.push_back(mk(6'b000100, 9'b000000000));
    // issue with simultaneous req drop; issue outside GNT_I* ignored; done with req drop
    vecs.push_back(mk(6'b010000, 9'b100010000));
    vecs.push_back(mk(6'b000010, 9'b000001000));
    vecs.push_back(mk(6'b000110, 9'b001111000));
    vecs.push_back(mk(6'b000001, 9'b000000000));
    vecs.push_back(mk(6'b000000, 9'b000000000));

    @(negedge clk);
    foreach (vecs[i]) step_check(vecs[i].in, vecs[i].exp, $sformatf("vec%0d", i));

    // Watchdog: pointer favours initiator 1 here; it holds 8 cycles, then is forced off.
    for (int c = 0; c < 8; c++)
      step_check(6'b011000, 9'b010100000, $sformatf("wd_hold%0d", c));
    step_check(6'b011000, 9'b000000010, "wd_release");
    step_check(6'b011000, 9'b100010000, "wd_next_i1");
    step_check(6'b000000, 9'b000000000, "wd_drop");
    step_check(6'b000000, 9'b000000000, "wd_idle");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
